// File: rtl/median_filter_pkg.sv
// Shared definitions for the median window filter: run-control state encoding
// and the window lengths the sorting network supports.
package median_filter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int WINDOW_3 = 3;
    localparam int WINDOW_5 = 5;

    function automatic bit window_legal(input int w);
        return (w == WINDOW_3) || (w == WINDOW_5);
    endfunction

endpackage

// File: rtl/median_sort_net.sv
// Combinational median select: each element's rank is the number of elements
// ordered before it (index breaks ties), and the element of middle rank wins.
module median_sort_net
    import median_filter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 3,
    parameter int SIGNED = 0
) (
    input  logic [WINDOW-1:0][WIDTH-1:0] window,
    output logic [WIDTH-1:0]             median
);

    localparam int RANK = (WINDOW - 1) / 2;

    if (!window_legal(WINDOW)) begin : g_bad_window
        $error("median_sort_net: WINDOW must be 3 or 5");
    end

    // Strict total order: ties resolve by slot index, so every rank is unique
    // and equal values always yield the same median value.
    function automatic logic precedes(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input int ia, input int ib);
        logic lt;
        logic eq;
        lt = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
        eq = (a == b);
        return lt || (eq && (ia < ib));
    endfunction

    always_comb begin
        int rank;
        median = '0;
        for (int i = 0; i < WINDOW; i++) begin
            rank = 0;
            for (int j = 0; j < WINDOW; j++) begin
                if (j != i && precedes(window[j], window[i], j, i)) rank = rank + 1;
            end
            if (rank == RANK) median = window[i];
        end
    end

endmodule

// File: rtl/median_window_filter.sv
// Streaming median filter: fills a WINDOW-deep sample window, then emits the
// median of the newest WINDOW samples for every further accepted sample.
module median_window_filter
    import median_filter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 3,
    parameter int CNT_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

    if (!window_legal(WINDOW)) begin : g_bad_window
        $error("median_window_filter: WINDOW must be 3 or 5");
    end

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; ready never depends on the same side's valid.
    state_t                        state;
    logic [CNT_W-1:0]              len_q;
    logic [CNT_W-1:0]              cnt;
    logic [WINDOW-1:0][WIDTH-1:0]  win;
    logic [WINDOW-1:0][WIDTH-1:0]  win_next;
    logic [WIDTH-1:0]              median;
    logic                          in_fire;
    logic                          out_fire;
    logic                          last_accept;
    logic                          unused_oldest;

    assign in_ready    = (state == S_FILL || state == S_RUN) && (!out_valid || out_ready)
                         && (cnt < len_q);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign busy        = (state != S_IDLE);
    assign dbg_state   = state;
    assign last_accept = ((cnt + CNT_W'(1)) == len_q);

    // Newest sample enters slot 0; the oldest slot falls out on the next shift.
    assign win_next      = {win[WINDOW-2:0], in_data};
    assign unused_oldest = ^win[WINDOW-1];

    median_sort_net #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW),
        .SIGNED (SIGNED)
    ) u_sort (
        .window (win_next),
        .median (median)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            win       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_fire) begin
                win <= win_next;
                cnt <= cnt + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_q <= len;
                            cnt   <= '0;
                            state <= S_FILL;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (in_fire) begin
                        if (last_accept) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (cnt == CNT_W'(WINDOW - 2)) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (in_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= median;
                    end else if (cnt == len_q && (!out_valid || out_ready)) begin
                        out_valid <= 1'b0;
                        state     <= S_DONE;
                        done      <= 1'b1;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_filter.sv
// Bench for median_window_filter: three instances (W3 unsigned, W3 signed,
// W5 unsigned) driven by directed and random runs against a sorting model.
module tb_median_window_filter;
    import median_filter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_a     [3];
    logic [31:0] len_a       [3];
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic [31:0] in_data_a   [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic [31:0] out_data_a  [3];
    logic        busy_a      [3];
    logic        done_a      [3];
    state_t      st_a        [3];

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] smp[$];

    median_window_filter #(.WIDTH(32), .WINDOW(3), .CNT_W(32), .SIGNED(0)) u_w3u (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .len(len_a[0]),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_data(in_data_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_data(out_data_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .dbg_state(st_a[0]));

    median_window_filter #(.WIDTH(32), .WINDOW(3), .CNT_W(32), .SIGNED(1)) u_w3s (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .len(len_a[1]),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_data(in_data_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_data(out_data_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .dbg_state(st_a[1]));

    median_window_filter #(.WIDTH(32), .WINDOW(5), .CNT_W(32), .SIGNED(0)) u_w5u (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .len(len_a[2]),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_data(in_data_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_data(out_data_a[2]),
        .busy(busy_a[2]), .done(done_a[2]), .dbg_state(st_a[2]));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int win_of(input int k);
        return (k == 2) ? 5 : 3;
    endfunction

    // Reference: sort the window (signed order via sign-bit bias) and take the middle.
    function automatic logic [31:0] ref_median(input logic [31:0] w[$], input bit sgn);
        logic [31:0] t[$];
        logic [31:0] bias;
        bias = sgn ? 32'h8000_0000 : 32'h0;
        foreach (w[i]) t.push_back(w[i] ^ bias);
        t.sort();
        return t[(t.size() - 1) / 2] ^ bias;
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0; len_a[k] = '0; in_valid_a[k] = 1'b0;
            in_data_a[k] = '0; out_ready_a[k] = 1'b0;
        end
    endtask

    // mode 0: always valid/ready; 1: random valid/ready; 2: 3-cycle stall at first output
    task automatic do_run(input int k, input int len, input logic [31:0] s[$], input int mode);
        logic [31:0] exp_q[$];
        logic [31:0] w[$];
        int wn = win_of(k);
        bit sg = (k == 1);
        int idx = 0, done_cnt = 0, done_cyc = -1, last_acc = -1, last_out = -1;
        int stall_left = 0, exp_dc;
        bit stalled_once = 0, prev_stall = 0;
        logic [31:0] prev_data = '0;
        for (int e = wn - 1; e < len; e++) begin
            w.delete();
            for (int j = e - wn + 1; j <= e; j++) w.push_back(s[j]);
            exp_q.push_back(ref_median(w, sg));
        end
        start_a[k] = 1'b1; len_a[k] = len;
        @(negedge clk);
        start_a[k] = 1'b0;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            if (done_a[k]) begin done_cnt++; done_cyc = c; end
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid_a[k]), 32'd1);
                check("hold_data", out_data_a[k], prev_data);
            end
            in_valid_a[k] = (idx < len) && (mode != 1 || $urandom_range(0, 3) != 0);
            in_data_a[k]  = (idx < len) ? s[idx] : $urandom();
            if (mode == 2 && out_valid_a[k] && !stalled_once) begin
                stalled_once = 1; stall_left = 3;
            end
            if (mode == 1) out_ready_a[k] = ($urandom_range(0, 2) != 0);
            else if (stall_left > 0) begin out_ready_a[k] = 1'b0; stall_left--; end
            else out_ready_a[k] = 1'b1;
            #1;
            if (out_valid_a[k] && !out_ready_a[k]) check("stall_in_ready", 32'(in_ready_a[k]), 32'd0);
            if (idx >= len) check("in_ready_after_len", 32'(in_ready_a[k]), 32'd0);
            if (in_valid_a[k] && in_ready_a[k]) begin idx++; last_acc = c; end
            if (out_valid_a[k] && out_ready_a[k]) begin
                if (exp_q.size() == 0) check("extra_output", 32'(out_valid_a[k]), 32'd0);
                else begin
                    check("out_data", out_data_a[k], exp_q.pop_front());
                    last_out = c;
                end
            end
            prev_stall = out_valid_a[k] && !out_ready_a[k];
            prev_data  = out_data_a[k];
            @(negedge clk);
        end
        in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0;
        exp_dc = (len == 0) ? 0 : ((len < wn) ? last_acc + 1 : last_out + 1);
        check("done_count", done_cnt, 1);
        check("outputs_left", exp_q.size(), 0);
        check("accepted", idx, len);
        check("done_timing", done_cyc, exp_dc);
        check("idle_busy", 32'(busy_a[k]), 32'd0);
        check("idle_done", 32'(done_a[k]), 32'd0);
    endtask

    initial begin
        int len;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_out_valid", 32'(out_valid_a[k]), 32'd0);
            check("rst_out_data", out_data_a[k], 32'd0);
            check("rst_done", 32'(done_a[k]), 32'd0);
            check("rst_busy", 32'(busy_a[k]), 32'd0);
            check("rst_in_ready", 32'(in_ready_a[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run 5,1,9,3,7 -> 5,3,7
        smp.delete(); smp.push_back(5); smp.push_back(1); smp.push_back(9);
        smp.push_back(3); smp.push_back(7);
        do_run(0, 5, smp, 0);
        // Same run with a 3-cycle consumer stall after the first output
        do_run(0, 5, smp, 2);

        // Sign-sensitive ordering
        smp.delete(); smp.push_back(32'hFFFF_FFFF); smp.push_back(32'd2);
        smp.push_back(32'hFFFF_FFFB);
        do_run(1, 3, smp, 0);
        do_run(0, 3, smp, 0);

        // Short runs: fewer samples than the window, and empty
        smp.delete(); smp.push_back(8); smp.push_back(3);
        do_run(0, 2, smp, 0);
        do_run(0, 0, smp, 0);
        do_run(2, 4, smp, 1);

        // Five-wide window
        smp.delete(); smp.push_back(10); smp.push_back(50); smp.push_back(20);
        smp.push_back(40); smp.push_back(30); smp.push_back(60);
        do_run(2, 6, smp, 0);

        // Reset in the middle of a run
        start_a[0] = 1'b1; len_a[0] = 5;
        @(negedge clk);
        start_a[0] = 1'b0; out_ready_a[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_a[0] = 1'b1; in_data_a[0] = (i % 2 == 0) ? 32'd99 : 32'd77;
            @(negedge clk);
        end
        in_valid_a[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid_a[0]), 32'd0);
        check("midrst_out_data", out_data_a[0], 32'd0);
        check("midrst_busy", 32'(busy_a[0]), 32'd0);
        check("midrst_in_ready", 32'(in_ready_a[0]), 32'd0);
        check("midrst_done", 32'(done_a[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 32'(done_a[0]), 32'd0);
        smp.delete(); smp.push_back(4); smp.push_back(4); smp.push_back(8);
        do_run(0, 3, smp, 0);

        // Random runs with random handshakes; narrow values on even runs force ties
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 10);
            smp.delete();
            for (int i = 0; i < len; i++)
                smp.push_back((r % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom());
            do_run(r % 3, len, smp, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
